keypad_scanner: RTL

- Upstream input stage for the 24-game controller.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and rejects multi-key presses.
- Produces a stable 4-bit `decode` key code. The game FSM acts on changes of this code: keys 1-4 select numbers, A-D select the operator.
- `decode` holds the code while a key is held and returns to 4'h0 on release, so repeated presses of the same key produce distinct transitions.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_scan_core.sv | 83 ++++++++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    typedef enum logic [1:0] {NONE, KEY, MULTI} scan_kind_t;

    localparam logic [3:0] KEY_IDLE = 4'h0;

    // Indexed by {row, col}; entry 0 is the rightmost element.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_scan_core.sv
// Row synchroniser, column drive and per-scan accumulation; one scan_done strobe per 4*SCAN_DIV clks.
// Latency: 2-flop row sync, result registered on the cycle after the column-3 sample.
// Backpressure: none, free-running scan; consumer must take scan_done when it fires.
module keypad_scan_core
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic       o_scan_done,
    output scan_kind_t o_scan_kind,
    output logic [3:0] o_scan_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_col;
    logic [1:0]       r_acc_cnt;
    logic [3:0]       r_acc_code;
    logic [1:0]       w_cnt;
    logic [3:0]       w_code;
    logic             w_tick;

    assign w_tick = (r_div == DIV_LAST);
    assign o_col  = r_col;

    // Fold the current column's low rows into the running scan totals; count saturates at 2.
    always_comb begin
        w_cnt  = r_acc_cnt;
        w_code = r_acc_code;
        for (int r = 0; r < 4; r++) begin
            if (!r_row_s2[r]) begin
                w_cnt  = (w_cnt == 2'd2) ? 2'd2 : w_cnt + 2'd1;
                w_code = key_lookup(2'(r), r_col_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1    <= 4'hF;
            r_row_s2    <= 4'hF;
            r_div       <= '0;
            r_col_idx   <= 2'd0;
            r_col       <= 4'b1110;
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= KEY_IDLE;
            o_scan_done <= 1'b0;
            o_scan_kind <= NONE;
            o_scan_code <= KEY_IDLE;
        end else begin
            r_row_s1    <= i_row;
            r_row_s2    <= r_row_s1;
            o_scan_done <= 1'b0;
            if (w_tick) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
                if (r_col_idx == 2'd3) begin
                    o_scan_done <= 1'b1;
                    o_scan_kind <= (w_cnt == 2'd0) ? NONE : ((w_cnt == 2'd1) ? KEY : MULTI);
                    o_scan_code <= w_code;
                    r_acc_cnt   <= 2'd0;
                    r_acc_code  <= KEY_IDLE;
                end else begin
                    r_acc_cnt   <= w_cnt;
                    r_acc_code  <= w_code;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with scan-level debounce and multi-key rejection; KEYPAD_REPEAT_EN adds auto-repeat pulses.
// Latency: outputs update one clk after the DEBOUNCE_SCANS-th qualifying scan completes.
// Backpressure: none; decode/key_valid are levels, key_pulse is a single-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] decode,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic             w_scan_done;
    scan_kind_t       w_kind;
    logic [3:0]       w_code;
    logic             w_rep_fire;

    state_t           r_state;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_decode;
    logic             r_valid;
    logic             r_pulse;

    keypad_scan_core #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_row       (row),
        .o_col       (col),
        .o_scan_done (w_scan_done),
        .o_scan_kind (w_kind),
        .o_scan_code (w_code)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_SCANS - 1);
    logic [CNT_W-1:0] r_rep;

    // Held outside HELD, so it is already clear on the cycle HELD is entered.
    always_ff @(posedge clk) begin
        if (rst || r_state != HELD) begin
            r_rep <= '0;
        end else if (w_scan_done && w_kind != NONE) begin
            r_rep <= (r_rep == REP_LAST) ? '0 : r_rep + CNT_W'(1);
        end
    end

    assign w_rep_fire = (r_state == HELD) && w_scan_done && (w_kind != NONE) && (r_rep == REP_LAST);
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cand   <= KEY_IDLE;
            r_cnt    <= '0;
            r_decode <= KEY_IDLE;
            r_valid  <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_scan_done) begin
                case (r_state)
                    IDLE: begin
                        if (w_kind == KEY) begin
                            r_state <= PRESS_DB;
                            r_cand  <= w_code;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS_DB: begin
                        if (w_kind == KEY && w_code == r_cand) begin
                            if (r_cnt == DB_LAST) begin
                                r_state  <= HELD;
                                r_cnt    <= CNT_W'(DEBOUNCE_SCANS);
                                r_decode <= r_cand;
                                r_valid  <= 1'b1;
                                r_pulse  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else if (w_kind == KEY) begin
                            r_cand <= w_code;
                            r_cnt  <= CNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    HELD: begin
                        // A second key or a chord never replaces the held code.
                        if (w_kind == NONE) begin
                            r_state <= REL_DB;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_pulse <= w_rep_fire;
                        end
                    end
                    REL_DB: begin
                        if (w_kind == NONE) begin
                            if (r_cnt == DB_LAST) begin
                                r_state  <= IDLE;
                                r_cnt    <= '0;
                                r_decode <= KEY_IDLE;
                                r_valid  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign decode    = r_decode;
    assign key_valid = r_valid;
    assign key_pulse = r_pulse;

endmodule
